// File: rtl/event_period_meter.sv
// event_period_meter
// ------------------
// Measures the number of clk cycles between successive rising edges of an
// asynchronous event input, then hands each measured period to a downstream
// consumer over a valid/ready interface. It runs continuously: every detected
// edge closes one period and opens the next.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   enable        measurement enable; low forces IDLE and clears the counter
//   event_in      asynchronous event input whose rising edges are measured
//   period_out    last captured period in clk cycles (COUNT_W bits)
//   period_valid  period_out holds a result the consumer has not taken yet
//   period_ready  consumer accepts the result when period_valid is high
//   overflow      period_out saturated at 2^COUNT_W-1
//   overrun       sticky: a pending result was overwritten before acceptance
//   busy          high while in the MEASURE state
module event_period_meter #(
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               event_in,
    output logic [COUNT_W-1:0] period_out,
    output logic               period_valid,
    input  logic               period_ready,
    output logic               overflow,
    output logic               overrun,
    output logic               busy
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_prev_reg;
    logic                   edge_pulse_reg;

    logic [COUNT_W-1:0] counter_reg, counter_next;
    logic [COUNT_W-1:0] period_reg, period_next;
    logic               valid_reg, valid_next;
    logic               overflow_reg, overflow_next;
    logic               overrun_reg, overrun_next;

    // Synchronizer and edge detector. The edge pulse is registered, so the
    // FSM sees it SYNC_STAGES+1 cycles after event_in rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg       <= '0;
            sync_prev_reg  <= 1'b0;
            edge_pulse_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], event_in};
            sync_prev_reg  <= sync_reg[SYNC_STAGES-1];
            edge_pulse_reg <= sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            period_reg   <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            period_reg   <= period_next;
            valid_reg    <= valid_next;
            overflow_reg <= overflow_next;
            overrun_reg  <= overrun_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        period_next   = period_reg;
        valid_next    = valid_reg;
        overflow_next = overflow_reg;
        overrun_next  = overrun_reg;

        // The handshake completes independently of enable; a capture below
        // may re-assert valid in the same cycle.
        if (valid_reg && period_ready) begin
            valid_next = 1'b0;
        end

        if (!enable) begin
            // Any edge in this cycle is ignored. The overrun flag is only
            // cleared once the FSM has actually settled in IDLE.
            state_next   = IDLE;
            counter_next = '0;
            if (state_reg == IDLE) begin
                overrun_next = 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    counter_next = '0;
                    // First edge only opens a period; nothing to capture yet.
                    if (edge_pulse_reg) begin
                        counter_next = COUNT_ONE;
                        state_next   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_pulse_reg) begin
                        period_next   = counter_reg;
                        overflow_next = (counter_reg == COUNT_MAX);
                        valid_next    = 1'b1;
                        counter_next  = COUNT_ONE;
                        // A simultaneous accept is a clean handoff.
                        if (valid_reg && !period_ready) begin
                            overrun_next = 1'b1;
                        end
                    end else if (counter_reg != COUNT_MAX) begin
                        counter_next = counter_reg + COUNT_ONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign period_out   = period_reg;
    assign period_valid = valid_reg;
    assign overflow     = overflow_reg;
    assign overrun      = overrun_reg;
    assign busy         = (state_reg == MEASURE);

endmodule

// File: tb/tb_event_period_meter.sv
// tb_event_period_meter
// ---------------------
// Self-checking bench for event_period_meter (COUNT_W=8 so saturation is
// reachable quickly). Stimulus records the cycle in which each rising edge
// reaches the measuring logic and pushes the expected period into a queue;
// a monitor on the falling clock edge pops and compares every accepted result.
module tb_event_period_meter;

    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;
    // Cycles from driving event_in high to the capture clock edge.
    localparam int DET_LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          event_in;
    logic [CW-1:0] period_out;
    logic          period_valid;
    logic          period_ready;
    logic          overflow;
    logic          overrun;
    logic          busy;

    event_period_meter #(
        .COUNT_W    (CW),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .event_in    (event_in),
        .period_out  (period_out),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .overflow    (overflow),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        int ovf;
        int cap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   vhigh    = 0;
    bit   armed    = 1'b0;
    int   last_det = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Raise event_in for two cycles. The reference model: a period is the
    // distance between consecutive edges seen while enabled, saturating at
    // MAXV; the first edge after reset/enable only opens a period.
    task automatic rise();
        int   det;
        int   diff;
        exp_t e;
        det      = cyc + DET_LAT;
        event_in = 1'b1;
        if (!enable) begin
            armed = 1'b0;
        end else begin
            if (armed) begin
                diff    = det - last_det;
                e.value = (diff > MAXV) ? MAXV : diff;
                e.ovf   = (diff >= MAXV) ? 1 : 0;
                e.cap   = det;
                exp_q.push_back(e);
            end
            armed    = 1'b1;
            last_det = det;
        end
        tick();
        tick();
        event_in = 1'b0;
    endtask

    // Monitor: an accept at the next rising edge sees the most recent result
    // captured before that edge; older unaccepted results were overwritten.
    always @(negedge clk) begin
        int   p;
        exp_t e;
        if (!reset) begin
            if (period_valid) vhigh++;
            if (period_valid && period_ready) begin
                p = cyc + 1;
                while (exp_q.size() > 1 && exp_q[1].cap < p) void'(exp_q.pop_front());
                $display("accept @%0d period=%0d overflow=%0d", p, period_out, overflow);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got period %0d, required no result", period_out);
                end else begin
                    e = exp_q.pop_front();
                    check("period", int'(period_out), e.value);
                    check("overflow", int'(overflow), e.ovf);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int gap;
        reset        = 1'b1;
        enable       = 1'b0;
        event_in     = 1'b0;
        period_ready = 1'b1;
        idle(3);
        check("rst_period", int'(period_out), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        reset  = 1'b0;
        enable = 1'b1;
        idle(2);

        // Basic: four edges 50 cycles apart -> three single-cycle results.
        v0 = vhigh;
        repeat (4) begin
            rise();
            idle(48);
        end
        check("basic_valid_cycles", vhigh - v0, 3);
        check("basic_overrun", int'(overrun), 0);
        check("basic_busy", int'(busy), 1);

        // Saturation: 300 then 100 cycles.
        rise();
        idle(298);
        rise();
        idle(4);
        check("sat_period", int'(period_out), MAXV);
        check("sat_overflow", int'(overflow), 1);
        idle(94);
        rise();
        idle(8);
        check("sat_after_period", int'(period_out), 100);
        check("sat_after_overflow", int'(overflow), 0);

        // Backpressure: 40 held, then overwritten by 60.
        period_ready = 1'b0;
        idle(30);
        rise();
        idle(8);
        check("bp_hold_period", int'(period_out), 40);
        check("bp_hold_valid", int'(period_valid), 1);
        check("bp_hold_overrun", int'(overrun), 0);
        idle(50);
        rise();
        idle(8);
        check("bp_new_period", int'(period_out), 60);
        check("bp_overrun", int'(overrun), 1);
        check("bp_valid", int'(period_valid), 1);
        period_ready = 1'b1;
        tick();
        check("bp_valid_drop", int'(period_valid), 0);
        check("bp_overrun_sticky", int'(overrun), 1);

        // Enable drop with a pending result of 35.
        period_ready = 1'b0;
        idle(24);
        rise();
        idle(10);
        enable = 1'b0;
        armed  = 1'b0;
        idle(2);
        check("dis_busy", int'(busy), 0);
        check("dis_valid_kept", int'(period_valid), 1);
        check("dis_period_kept", int'(period_out), 35);
        idle(5);
        check("dis_overrun_clr", int'(overrun), 0);
        rise();
        idle(10);
        check("dis_busy_edge", int'(busy), 0);
        period_ready = 1'b1;
        tick();
        check("dis_handshake", int'(period_valid), 0);
        enable = 1'b1;
        idle(5);
        rise();
        idle(28);
        rise();
        idle(8);
        check("reen_period", int'(period_out), 30);
        check("reen_busy", int'(busy), 1);

        // Accept in the very cycle of a capture: clean handoff.
        period_ready = 1'b0;
        idle(10);
        rise();
        idle(23);
        rise();
        idle(1);
        period_ready = 1'b1;
        tick();
        period_ready = 1'b0;
        check("sim_valid", int'(period_valid), 1);
        check("sim_period", int'(period_out), 25);
        check("sim_overrun", int'(overrun), 0);
        idle(3);
        period_ready = 1'b1;
        idle(3);

        // Reset with a pending result.
        period_ready = 1'b0;
        idle(20);
        rise();
        idle(8);
        check("mr_valid_before", int'(period_valid), 1);
        reset = 1'b1;
        tick();
        exp_q.delete();
        armed = 1'b0;
        check("mr_period", int'(period_out), 0);
        check("mr_valid", int'(period_valid), 0);
        check("mr_overflow", int'(overflow), 0);
        check("mr_overrun", int'(overrun), 0);
        check("mr_busy", int'(busy), 0);
        reset        = 1'b0;
        period_ready = 1'b1;
        idle(5);
        rise();
        idle(23);
        rise();
        idle(8);
        check("mr_fresh_period", int'(period_out), 25);

        // Random periods (including saturating ones) with random backpressure.
        for (int i = 0; i < 40; i++) begin
            gap = int'($urandom_range(4, 300));
            rise();
            repeat (gap - 2) begin
                period_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        period_ready = 1'b1;
        idle(20);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/event_period_meter.md
Name: event_period_meter

Overview:
- Measures the interval, in clk cycles, between successive rising edges of an asynchronous event input.
- It is the measuring counterpart of the tick generator: the generator turns a cycle count into a periodic pulse, and this block turns a periodic pulse back into a cycle count.
- Results are delivered on a valid/ready output interface to a downstream consumer, for example a display or frequency-calculation stage.
- It runs continuously: every rising edge closes one period and opens the next.

Parameters:
- COUNT_W, 16: width of the period counter and of period_out.
- SYNC_STAGES, 2: number of flip-flops in the event_in synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  measurement enable; low forces IDLE.
- event_in  input  1  asynchronous event signal; its rising edges are measured.
- period_out  output  COUNT_W  last captured period, in clk cycles.
- period_valid  output  1  period_out holds an unconsumed result.
- period_ready  input  1  consumer accepts the result when period_valid is high.
- overflow  output  1  qualifies period_out: the period saturated at 2^COUNT_W-1.
- overrun  output  1  sticky: a result was overwritten before it was accepted.
- busy  output  1  high while in the MEASURE state.

Behaviour:
- Reset values: period_out=0, period_valid=0, overflow=0, overrun=0, busy=0. Synchronizer and edge-detect flops are 0, counter is 0, state is IDLE.
- Synchronizer: event_in passes through SYNC_STAGES flops. A rising edge is detected as sync_now & ~sync_prev, registered as a 1-cycle pulse called edge.
- Edge latency: edge asserts SYNC_STAGES+1 cycles after event_in rises.
- State IDLE:
  - busy=0, counter held at 0.
  - On edge with enable=1: counter <= 1, go to MEASURE. Nothing is captured.
- State MEASURE, cycles without edge:
  - counter <= counter+1.
  - The counter saturates at 2^COUNT_W-1 and never wraps.
- State MEASURE, cycle with edge (capture):
  - period_out <= counter; overflow <= (counter == 2^COUNT_W-1); period_valid <= 1.
  - counter <= 1; stay in MEASURE.
- Resulting value: if edges are detected at cycles t0 and t1, period_out = t1-t0, and period_valid rises at t1+1.
- Handshake:
  - The result and overflow are held stable while period_valid=1 and period_ready=0.
  - period_valid & period_ready with no capture in the same cycle: period_valid <= 0 next cycle.
  - Capture in a cycle with period_valid=1 and period_ready=1: the new result loads and period_valid stays 1. This is a clean handoff with no overrun.
  - Capture in a cycle with period_valid=1 and period_ready=0: the new result overwrites the old one and overrun <= 1.
- overrun is sticky. It is cleared only by reset, or by enable=0 while in IDLE.
- enable deasserted (any state):
  - Next state is IDLE and the counter is cleared.
  - An edge in that same cycle is ignored.
  - period_out, period_valid and overflow are retained; the handshake still completes normally.
- enable reasserted: the first subsequent edge only restarts measurement, with no capture.
- Minimum resolvable period is 2 cycles, because edge detection needs event_in to be sampled low between edges. Behaviour for faster inputs is undefined.
- Reset mid-operation: all state returns to the reset values on the next clock, regardless of handshake state.

Test Plan:
- Basic period:
  - Stimulus: enable=1, period_ready=1, event_in toggled with a period of 50 cycles for 4 edges.
  - Required: the first edge gives no result; then 3 results of period_out=50, each period_valid pulse 1 cycle wide; overflow=0; overrun=0.
- Saturation:
  - Stimulus: COUNT_W=8, edges 300 cycles apart, then 100 cycles apart.
  - Required: period_out=255 with overflow=1, then period_out=100 with overflow=0.
- Backpressure:
  - Stimulus: period_ready=0 across two captures of 40 and 60 cycles.
  - Required: period_out=40 held stable, then replaced by 60; overrun=1 and stays 1; asserting period_ready drops period_valid next cycle.
- Simultaneous accept and capture:
  - Stimulus: period_ready=1 exactly on a capture cycle while period_valid=1.
  - Required: the new value is loaded, period_valid stays 1, overrun stays 0.
- Enable drop:
  - Stimulus: enable=0 mid-period, then enable=1; next edges 30 cycles apart.
  - Required: busy=0 while disabled; the prior result is retained; the first edge after re-enable gives no result; the next result is 30; overrun is cleared by the IDLE/enable=0 condition.
- Reset mid-measure:
  - Stimulus: reset=1 for 1 cycle with period_valid=1.
  - Required: all outputs are 0 the following cycle, and the next edge starts a fresh measurement.
